// File: rtl/bin_to_bcd_scan_if.sv
// Load/result bundle between the multiplier result register, the BCD scan engine
// and the BCD-to-cathode decoder.
interface bin_to_bcd_scan_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIGITS = 3
) ();
  logic [WIDTH-1:0]      valor;
  logic                  cargar;
  logic                  ocupado;
  logic                  listo;
  logic                  negativo;
  logic [3:0]            digito;
  logic [NUM_DIGITS-1:0] anodo;

  modport master (
    output valor, cargar,
    input  ocupado, listo, negativo, digito, anodo
  );

  modport slave (
    input  valor, cargar,
    output ocupado, listo, negativo, digito, anodo
  );
endinterface

// File: rtl/bin_to_bcd_scan.sv
// Sequential double-dabble binary-to-BCD converter feeding a time-multiplexed
// common-anode digit scanner (one BCD code plus active-low anode enables).
module bin_to_bcd_scan #(
  parameter int WIDTH       = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 100000,
  parameter int SIGNED      = 1
) (
  input  logic               clk,
  input  logic               rst,
  bin_to_bcd_scan_if.slave   io_bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [WIDTH-1:0]      r_mag;
  logic [BCD_W-1:0]      r_bcd;
  logic [BCD_W-1:0]      r_disp;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign;
  logic                  r_neg;
  logic                  r_listo;
  logic [IDX_W-1:0]      r_idx;
  logic [REF_W-1:0]      r_refresh;

  logic [BCD_W-1:0]      w_bcd_adj;
  logic [WIDTH-1:0]      w_mag;
  logic                  w_sign;
  logic [3:0]            w_digito;
  logic [NUM_DIGITS-1:0] w_anodo;
  logic                  w_refresh_wrap;
  logic                  w_idx_last;

  // Most negative input negates to itself, which read as unsigned is the right magnitude.
  assign w_sign = (SIGNED != 0) && io_bus.valor[WIDTH-1];
  assign w_mag  = w_sign ? (~io_bus.valor + 1'b1) : io_bus.valor;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] w_nib;
      assign w_nib                 = r_bcd[4*gi +: 4];
      assign w_bcd_adj[4*gi +: 4]  = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
      assign w_anodo[gi]           = (r_idx != IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_disp  <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_neg   <= 1'b0;
      r_listo <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.cargar) begin
            r_mag   <= w_mag;
            r_sign  <= w_sign;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          // Display only changes here, after all WIDTH shifts, so no partial value is shown.
          if (r_cnt == '0) begin
            r_disp  <= r_bcd;
            r_neg   <= r_sign;
            r_listo <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bcd <= {w_bcd_adj[BCD_W-2:0], r_mag[WIDTH-1]};
            r_mag <= {r_mag[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_listo <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_listo <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_refresh_wrap = (r_refresh == REF_W'(REFRESH_DIV - 1));
  assign w_idx_last     = (r_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= '0;
    end else if (w_refresh_wrap) begin
      r_refresh <= '0;
      r_idx     <= w_idx_last ? '0 : (r_idx + 1'b1);
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  always_comb begin
    w_digito = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digito = r_disp[4*i +: 4];
      end
    end
  end

  assign io_bus.ocupado  = (r_state != S_IDLE);
  assign io_bus.listo    = r_listo;
  assign io_bus.negativo = r_neg;
  assign io_bus.digito   = w_digito;
  assign io_bus.anodo    = w_anodo;

endmodule

// File: tb/tb_bin_to_bcd_scan.sv
// Bench for bin_to_bcd_scan: an unsigned and a signed instance, directed cases
// plus random loads checked against an arithmetic decimal-digit model.
module tb_bin_to_bcd_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_scan_if #(.WIDTH(8), .NUM_DIGITS(3)) if_u ();
  bin_to_bcd_scan_if #(.WIDTH(8), .NUM_DIGITS(3)) if_s ();

  bin_to_bcd_scan #(.WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(4), .SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .io_bus(if_u.slave)
  );
  bin_to_bcd_scan #(.WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(4), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .io_bus(if_s.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit sel = 1'b0;

  logic       m_ocupado, m_listo, m_negativo;
  logic [3:0] m_digito;
  logic [2:0] m_anodo;
  assign m_ocupado  = sel ? if_s.ocupado  : if_u.ocupado;
  assign m_listo    = sel ? if_s.listo    : if_u.listo;
  assign m_negativo = sel ? if_s.negativo : if_u.negativo;
  assign m_digito   = sel ? if_s.digito   : if_u.digito;
  assign m_anodo    = sel ? if_s.anodo    : if_u.anodo;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Magnitude the display must show, straight from the number's meaning.
  function automatic int ref_mag(input bit sgn, input logic [7:0] v);
    int x;
    x = int'(v);
    if (sgn && x >= 128) x = x - 256;
    return (x < 0) ? -x : x;
  endfunction

  task automatic start_load(input logic [7:0] v);
    if (sel) begin if_s.valor = v; if_s.cargar = 1'b1; end
    else     begin if_u.valor = v; if_u.cargar = 1'b1; end
    @(posedge clk);
    #1;
    if_s.cargar = 1'b0;
    if_u.cargar = 1'b0;
  endtask

  task automatic read_display(output int d0, output int d1, output int d2, output int bad);
    d0 = -1; d1 = -1; d2 = -1; bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      case (m_anodo)
        3'b110:  d0 = int'(m_digito);
        3'b101:  d1 = int'(m_digito);
        3'b011:  d2 = int'(m_digito);
        default: bad++;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input int m, input int neg);
    int d0, d1, d2, bad;
    read_display(d0, d1, d2, bad);
    check_val({tag, ".anodo_onehot"}, bad, 0);
    check_val({tag, ".units"}, d0, m % 10);
    check_val({tag, ".tens"}, d1, (m / 10) % 10);
    check_val({tag, ".hundreds"}, d2, m / 100);
    check_val({tag, ".negativo"}, int'(m_negativo), neg);
    $display("conv sel=%0d mag=%0d shown=%0d%0d%0d neg=%0d", sel, m, d2, d1, d0, m_negativo);
  endtask

  task automatic run_conv(input logic [7:0] v);
    int occ, lst, lst_pos, m;
    bit done;
    bit neg;
    @(posedge clk);
    #1;
    start_load(v);
    occ = 0; lst = 0; lst_pos = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (m_ocupado) begin
        occ++;
        if (m_listo) begin lst++; lst_pos = occ; end
      end else begin
        done = 1'b1;
      end
    end
    check_val("conv.finished", int'(done), 1);
    check_val("conv.ocupado_cycles", occ, 10);
    check_val("conv.listo_pulses", lst, 1);
    check_val("conv.listo_cycle", lst_pos, 10);
    m   = ref_mag(sel, v);
    neg = sel && v[7];
    check_digits("conv", m, int'(neg));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".u_anodo"},    int'(if_u.anodo), 6);
    check_val({tag, ".u_digito"},   int'(if_u.digito), 0);
    check_val({tag, ".u_ocupado"},  int'(if_u.ocupado), 0);
    check_val({tag, ".u_listo"},    int'(if_u.listo), 0);
    check_val({tag, ".s_anodo"},    int'(if_s.anodo), 6);
    check_val({tag, ".s_digito"},   int'(if_s.digito), 0);
    check_val({tag, ".s_ocupado"},  int'(if_s.ocupado), 0);
    check_val({tag, ".s_negativo"}, int'(if_s.negativo), 0);
  endtask

  logic [7:0] dir_vals [8] = '{8'd0, 8'd255, 8'd100, 8'd9, 8'h7F, 8'hFF, 8'h81, 8'd0};
  bit         dir_sel  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int lst, k, idx, m;
    logic [2:0] a, prev;
    bit synced;

    rst = 1'b1;
    if_u.valor = '0; if_u.cargar = 1'b0;
    if_s.valor = '0; if_s.cargar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    rst = 1'b0;

    // Unsigned 237 then scan pattern with REFRESH_DIV=4.
    sel = 1'b0;
    run_conv(8'd237);
    m = 237;
    prev = m_anodo;
    synced = 1'b0;
    for (int c = 0; c < 10 && !synced; c++) begin
      @(negedge clk);
      if (m_anodo != prev) synced = 1'b1;
      prev = m_anodo;
    end
    check_val("scan.sync", int'(synced), 1);
    a = m_anodo;
    k = 0;
    for (int i = 0; i < 3; i++) if (a[i] == 1'b0) k = i;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      idx = (k + c / 4) % 3;
      check_val("scan.anodo", int'(m_anodo), 7 & ~(1 << idx));
      check_val("scan.digito", int'(m_digito),
                (idx == 0) ? m % 10 : (idx == 1) ? (m / 10) % 10 : m / 100);
    end
    $display("scan checked 16 cycles from index %0d", k);

    // Strobe while busy must be ignored.
    @(posedge clk);
    #1;
    start_load(8'd99);
    @(posedge clk);
    #1;
    if_u.valor = 8'd5; if_u.cargar = 1'b1;
    @(posedge clk);
    #1;
    if_u.cargar = 1'b0;
    lst = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (m_listo) lst++;
    end
    check_val("busy.listo_pulses", lst, 1);
    check_digits("busy", 99, 0);

    // Signed boundary values.
    sel = 1'b1;
    run_conv(8'h80);
    run_conv(8'hF6);

    // Asynchronous reset between edges: outputs clear without waiting for a clock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset during conversion aborts it.
    sel = 1'b0;
    run_conv(8'd123);
    @(posedge clk);
    #1;
    start_load(8'd255);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val("abort.ocupado", int'(m_ocupado), 0);
    check_val("abort.digito", int'(m_digito), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lst = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_listo) lst++;
    end
    check_val("abort.listo_pulses", lst, 0);
    check_digits("abort", 0, 0);
    run_conv(8'd42);

    for (int i = 0; i < 8; i++) begin
      sel = dir_sel[i];
      run_conv(dir_vals[i]);
    end

    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      run_conv(8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
